// File: rtl/issue_scoreboard.sv
// Issue controller between decode and EX: per-register pending-write counters,
// RAW/saturation hold of decode, ID->EX issue qualification and drain sequencing.
module issue_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_dec_valid,
  input  logic [4:0] i_rs1,
  input  logic [4:0] i_rs2,
  input  logic [4:0] i_rd,
  input  logic       i_uses_rs1,
  input  logic       i_uses_rs2,
  input  logic       i_writes_rd,
  input  logic       i_ex_ready,
  input  logic       i_flush,
  input  logic       i_wb_valid,
  input  logic [4:0] i_wb_rd,
  input  logic       i_drain_req,
  output logic       o_issue,
  output logic       o_stall,
  output logic       o_busy,
  output logic       o_drain_done,
  output logic [1:0] o_state,
  output logic       o_sb_err
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [CNT_W-1:0] cnt [32];
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             sb_err;
  logic             hazard;
  logic             busy;
  logic             wb_err;
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;

  // cnt[0] is reset and never written, so x0 lookups always read zero
  always_comb begin
    hazard = (i_uses_rs1  && (i_rs1 != 5'd0) && (cnt[i_rs1] != '0)) ||
             (i_uses_rs2  && (i_rs2 != 5'd0) && (cnt[i_rs2] != '0)) ||
             (i_writes_rd && (i_rd  != 5'd0) && (cnt[i_rd]  == '1));
    o_issue = i_dec_valid && i_ex_ready && !i_flush && !i_drain_req &&
              (state == RUN) && !hazard;
    o_stall = !i_flush && ((state != RUN) || i_drain_req || (i_dec_valid && !o_issue));
  end

  always_comb begin
    busy    = 1'b0;
    inc_vec = '0;
    dec_vec = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      busy       = busy | (cnt[r] != '0);
      inc_vec[r] = o_issue && i_writes_rd && (i_rd == 5'(r));
      dec_vec[r] = i_wb_valid && (i_wb_rd == 5'(r)) && (cnt[r] != '0);
    end
    wb_err = i_wb_valid && (i_wb_rd != 5'd0) && (cnt[i_wb_rd] == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (i_drain_req) state_nxt = DRAIN;
      DRAIN:   if (!busy)       state_nxt = DONE;
      DONE:                     state_nxt = RUN;
      default:                  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < 32; r++) cnt[r] <= '0;
      state  <= RUN;
      sb_err <= 1'b0;
    end else begin
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
      state <= state_nxt;
      if (wb_err) sb_err <= 1'b1;
    end
  end

  assign o_busy       = busy;
  assign o_drain_done = (state == DONE);
  assign o_state      = state;
  assign o_sb_err     = sb_err;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic, all compared against a per-register integer-count reference model.
module tb_issue_scoreboard;

  localparam int unsigned CNT_W = 2;
  localparam int          MAX   = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_dec_valid, i_uses_rs1, i_uses_rs2, i_writes_rd;
  logic [4:0] i_rs1, i_rs2, i_rd, i_wb_rd;
  logic       i_ex_ready, i_flush, i_wb_valid, i_drain_req;
  logic       o_issue, o_stall, o_busy, o_drain_done, o_sb_err;
  logic [1:0] o_state;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: plain integer counts and a state number 0/1/2
  int m_cnt [32];
  int m_state;
  bit m_err;

  logic s_issue, s_stall;

  always #5 clk = ~clk;

  issue_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(i_dec_valid), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd),
    .i_uses_rs1(i_uses_rs1), .i_uses_rs2(i_uses_rs2), .i_writes_rd(i_writes_rd),
    .i_ex_ready(i_ex_ready), .i_flush(i_flush), .i_wb_valid(i_wb_valid),
    .i_wb_rd(i_wb_rd), .i_drain_req(i_drain_req),
    .o_issue(o_issue), .o_stall(o_stall), .o_busy(o_busy),
    .o_drain_done(o_drain_done), .o_state(o_state), .o_sb_err(o_sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_busy();
    for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_state = 0;
    m_err   = 1'b0;
  endtask

  task automatic drive_idle();
    i_dec_valid = 0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
    i_uses_rs1 = 0; i_uses_rs2 = 0; i_writes_rd = 0;
    i_ex_ready = 0; i_flush = 0; i_wb_valid = 0; i_wb_rd = 0; i_drain_req = 0;
  endtask

  // asynchronous reset asserted away from any clock edge
  task automatic do_reset();
    #2;
    drive_idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_issue", 32'(o_issue), 0);
    check("rst_stall", 32'(o_stall), 0);
    check("rst_busy",  32'(o_busy), 0);
    check("rst_done",  32'(o_drain_done), 0);
    check("rst_state", 32'(o_state), 0);
    check("rst_err",   32'(o_sb_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one cycle: drive at negedge, compare just after, advance model at posedge
  task automatic step(input bit dv, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input bit u1, input bit u2, input bit wr,
                      input bit exr, input bit fl, input bit wbv, input logic [4:0] wbrd,
                      input bit dr);
    bit haz, iss, stl;
    int nxt [32];
    @(negedge clk);
    i_dec_valid = dv; i_rs1 = rs1; i_rs2 = rs2; i_rd = rd;
    i_uses_rs1 = u1; i_uses_rs2 = u2; i_writes_rd = wr;
    i_ex_ready = exr; i_flush = fl; i_wb_valid = wbv; i_wb_rd = wbrd; i_drain_req = dr;
    #1;
    haz = (u1 && rs1 != 0 && m_cnt[rs1] != 0) || (u2 && rs2 != 0 && m_cnt[rs2] != 0) ||
          (wr && rd != 0 && m_cnt[rd] == MAX);
    iss = dv && exr && !fl && !dr && m_state == 0 && !haz;
    stl = !fl && (m_state != 0 || dr || (dv && !iss));
    s_issue = o_issue;
    s_stall = o_stall;
    check("issue", 32'(o_issue), 32'(iss));
    check("stall", 32'(o_stall), 32'(stl));
    check("busy",  32'(o_busy), 32'(model_busy()));
    check("state", 32'(o_state), 32'(m_state));
    check("drain_done", 32'(o_drain_done), 32'(m_state == 2));
    check("sb_err", 32'(o_sb_err), 32'(m_err));
    @(posedge clk);
    nxt = m_cnt;
    if (iss && wr && rd != 0) nxt[rd]++;
    if (wbv && wbrd != 0) begin
      if (m_cnt[wbrd] != 0) nxt[wbrd]--;
      else m_err = 1'b1;
    end
    case (m_state)
      0: if (dr) m_state = 1;
      1: if (!model_busy()) m_state = 2;
      default: m_state = 0;
    endcase
    m_cnt = nxt;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b1;
    model_reset();
    do_reset();

    // RAW on x5: hold until writeback, then issue the following cycle
    step(1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 0, 0);
    check("raw_first_issue", 32'(s_issue), 1);
    step(1, 5, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
    check("raw_hold_issue", 32'(s_issue), 0);
    check("raw_hold_stall", 32'(s_stall), 1);
    step(1, 5, 0, 1, 1, 0, 1, 1, 0, 1, 5, 0);
    check("raw_no_bypass", 32'(s_issue), 0);
    step(1, 5, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    check("raw_issue_after_wb", 32'(s_issue), 1);
    idle_step();
    check("raw_cnt_cleared_busy", 32'(o_busy), 0);

    // x0 is never tracked
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    check("x0_write_issue", 32'(s_issue), 1);
    step(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    check("x0_read_issue", 32'(s_issue), 1);
    idle_step();
    check("x0_busy", 32'(o_busy), 0);

    // saturation of x7
    repeat (3) step(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0);
    check("sat_stall", 32'(s_stall), 1);
    check("sat_no_issue", 32'(s_issue), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 0);
    step(1, 0, 0, 7, 0, 0, 1, 1, 0, 1, 7, 0);
    check("sat_wb_and_issue", 32'(s_issue), 1);
    step(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0);
    check("sat_refill_issue", 32'(s_issue), 1);
    step(1, 0, 0, 7, 0, 0, 1, 1, 0, 0, 0, 0);
    check("sat_again_stall", 32'(s_stall), 1);

    // flush blocks issue without stalling
    step(1, 1, 2, 3, 1, 1, 1, 1, 1, 0, 0, 0);
    check("flush_issue", 32'(s_issue), 0);
    check("flush_stall", 32'(s_stall), 0);

    // drain with x3 in flight
    do_reset();
    step(1, 0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
    check("drain_req_stall", 32'(s_stall), 1);
    check("drain_req_no_issue", 32'(s_issue), 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    check("drain_state", 32'(o_state), 1);
    check("drain_stall_thru_flush", 32'(s_stall), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    repeat (4) idle_step();

    // drain with nothing in flight: DRAIN, DONE, RUN
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_step();
    check("idle_drain_state1", 32'(o_state), 1);
    idle_step();
    check("idle_drain_done", 32'(o_drain_done), 1);
    idle_step();
    check("idle_drain_run", 32'(o_state), 0);

    // stray writeback sets a sticky error; reset mid-drain clears everything
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("err_set", 32'(o_sb_err), 1);
    step(1, 0, 0, 4, 0, 0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_step();
    check("err_sticky", 32'(o_sb_err), 1);
    do_reset();

    // randomized traffic with periodic resets
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic [4:0] rs1, rs2, rd, wbrd;
      bit wbv;
      int start;
      if (cyc % 250 == 249) begin
        do_reset();
        continue;
      end
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      rd  = 5'($urandom_range(0, 7));
      wbv = 1'b0;
      wbrd = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 45) begin
        start = $urandom_range(0, 7);
        for (int k = 0; k < 8; k++)
          if (!wbv && m_cnt[(start + k) % 8] != 0) begin
            wbv = 1'b1;
            wbrd = 5'((start + k) % 8);
          end
      end
      if ($urandom_range(0, 99) < 2) wbv = 1'b1;
      step($urandom_range(0, 99) < 75, rs1, rs2, rd,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 70,
           $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 6,
           wbv, wbrd, $urandom_range(0, 99) < 4);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
